feature_skew_feeder: RTL and testbench

FEATURE_SKEW_FEEDER -- requirements
Module: feature_skew_feeder

---
 rtl/feature_skew_feeder.sv | 127 ++++++++++++
 tb/tb_feature_skew_feeder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_skew_feeder.sv
// Fetches one feature-memory word per cycle and skews its lanes so that row r of the
// systolic array sees its element r cycles after row 0.
module feature_skew_feeder #(
    parameter int unsigned N_ROWS_ARRAY     = 4,
    parameter int unsigned I_WIDTH          = 8,
    parameter int unsigned FEAT_ADDRS_WIDTH = 10
) (
    input  logic                             clk_i,
    input  logic                             f_sel_rst,
    input  logic                             rd_feature_ld_i,
    input  logic [FEAT_ADDRS_WIDTH-1:0]      base_addrs_i,
    input  logic [FEAT_ADDRS_WIDTH-1:0]      feature_len_i,
    input  logic [N_ROWS_ARRAY*I_WIDTH-1:0]  mem_data_i,
    output logic                             mem_rd_en_o,
    output logic [FEAT_ADDRS_WIDTH-1:0]      mem_addrs_o,
    output logic [I_WIDTH-1:0]               feature_o       [0:N_ROWS_ARRAY-1],
    output logic                             feature_valid_o [0:N_ROWS_ARRAY-1],
    output logic                             end_feature_o
);

    typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

    state_e                      state_q, state_d;
    logic [FEAT_ADDRS_WIDTH-1:0] base_q, base_d;
    logic [FEAT_ADDRS_WIDTH-1:0] len_q, len_d;
    logic [FEAT_ADDRS_WIDTH-1:0] idx_q, idx_d;
    logic                        end_q, end_d;
    // Tags the word arriving on mem_data_i this cycle (one-cycle memory latency).
    logic                        rd_en_q, rd_en_d;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        idx_d       = idx_q;
        mem_rd_en_o = 1'b0;
        mem_addrs_o = '0;
        unique case (state_q)
            StIdle: begin
                if (rd_feature_ld_i) begin
                    base_d  = base_addrs_i;
                    len_d   = feature_len_i;
                    idx_d   = '0;
                    state_d = (feature_len_i != '0) ? StFetch : StDone;
                end
            end
            StFetch: begin
                // Dropping the request aborts the pass without issuing this cycle's read.
                if (!rd_feature_ld_i) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    mem_rd_en_o = 1'b1;
                    mem_addrs_o = base_q + idx_q;
                    if (idx_q == len_q - FEAT_ADDRS_WIDTH'(1)) begin
                        state_d = StDone;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + FEAT_ADDRS_WIDTH'(1);
                    end
                end
            end
            StDone: begin
                if (!rd_feature_ld_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        end_d   = (state_d == StDone);
        rd_en_d = mem_rd_en_o;
    end

    always_ff @(posedge clk_i or posedge f_sel_rst) begin
        if (f_sel_rst) begin
            state_q <= StIdle;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            end_q   <= 1'b0;
            rd_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            end_q   <= end_d;
            rd_en_q <= rd_en_d;
        end
    end

    assign end_feature_o = end_q;

    // Lane r: r+1 stages; stage 0 captures memory data, the last stage drives the output.
    for (genvar r = 0; r < N_ROWS_ARRAY; r++) begin : g_lane
        logic [I_WIDTH-1:0] data_q [0:r];
        logic [I_WIDTH-1:0] data_d [0:r];
        logic [r:0]         valid_q, valid_d;

        always_comb begin
            valid_d[0] = rd_en_q;
            data_d[0]  = rd_en_q ? mem_data_i[r*I_WIDTH +: I_WIDTH] : '0;
            for (int s = 1; s <= r; s++) begin
                valid_d[s] = valid_q[s-1];
                data_d[s]  = data_q[s-1];
            end
        end

        always_ff @(posedge clk_i or posedge f_sel_rst) begin
            if (f_sel_rst) begin
                valid_q <= '0;
                for (int s = 0; s <= r; s++) begin
                    data_q[s] <= '0;
                end
            end else begin
                valid_q <= valid_d;
                for (int s = 0; s <= r; s++) begin
                    data_q[s] <= data_d[s];
                end
            end
        end

        assign feature_o[r]       = data_q[r];
        assign feature_valid_o[r] = valid_q[r];
    end

endmodule

// File: tb/tb_feature_skew_feeder.sv
// Randomised and directed bench for feature_skew_feeder against a pass-level reference model
// that schedules each fetched word onto lane r at issue cycle + 2 + r.
module tb_feature_skew_feeder;

    localparam int N     = 4;
    localparam int IW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    localparam int PhIdle  = 0;
    localparam int PhFetch = 1;
    localparam int PhDone  = 2;

    logic              clk_i           = 1'b0;
    logic              f_sel_rst       = 1'b1;
    logic              rd_feature_ld_i = 1'b0;
    logic [AW-1:0]     base_addrs_i    = '0;
    logic [AW-1:0]     feature_len_i   = '0;
    logic [N*IW-1:0]   mem_data_i      = '0;
    logic              mem_rd_en_o;
    logic [AW-1:0]     mem_addrs_o;
    logic [IW-1:0]     feature_o       [0:N-1];
    logic              feature_valid_o [0:N-1];
    logic              end_feature_o;

    feature_skew_feeder #(
        .N_ROWS_ARRAY     (N),
        .I_WIDTH          (IW),
        .FEAT_ADDRS_WIDTH (AW)
    ) dut (
        .clk_i           (clk_i),
        .f_sel_rst       (f_sel_rst),
        .rd_feature_ld_i (rd_feature_ld_i),
        .base_addrs_i    (base_addrs_i),
        .feature_len_i   (feature_len_i),
        .mem_data_i      (mem_data_i),
        .mem_rd_en_o     (mem_rd_en_o),
        .mem_addrs_o     (mem_addrs_o),
        .feature_o       (feature_o),
        .feature_valid_o (feature_valid_o),
        .end_feature_o   (end_feature_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory contents and one-cycle-latency read port.
    logic [N*IW-1:0] mem_words [DEPTH];

    always @(posedge clk_i) begin
        mem_data_i <= mem_rd_en_o ? mem_words[mem_addrs_o] : $urandom;
    end

    // Reference model state.
    int            ph = PhIdle;
    int            words_left = 0;
    logic [AW-1:0] next_addr = '0;
    bit            exp_end = 1'b0;
    bit            rst_seen = 1'b0;
    bit            sched_v [16][N];
    logic [IW-1:0] sched_d [16][N];

    int vcnt [N];
    int rd_cnt  = 0;
    int end_cnt = 0;

    always @(negedge clk_i) begin
        bit            exp_rd;
        logic [AW-1:0] exp_addr;
        int            slot;
        int            s;
        if (rst_seen || f_sel_rst) begin
            ph         = PhIdle;
            words_left = 0;
            exp_end    = 1'b0;
            for (int i = 0; i < 16; i++) begin
                for (int r = 0; r < N; r++) begin
                    sched_v[i][r] = 1'b0;
                    sched_d[i][r] = '0;
                end
            end
            rst_seen = 1'b0;
        end
        cyc++;
        exp_rd   = (ph == PhFetch) && rd_feature_ld_i;
        exp_addr = exp_rd ? next_addr : '0;
        chk("mem_rd_en_o", 32'(mem_rd_en_o), 32'(exp_rd));
        chk("mem_addrs_o", 32'(mem_addrs_o), 32'(exp_addr));
        chk("end_feature_o", 32'(end_feature_o), 32'(exp_end));
        slot = cyc % 16;
        for (int r = 0; r < N; r++) begin
            chk($sformatf("feature_valid_o[%0d]", r), 32'(feature_valid_o[r]),
                32'(sched_v[slot][r]));
            chk($sformatf("feature_o[%0d]", r), 32'(feature_o[r]),
                sched_v[slot][r] ? 32'(sched_d[slot][r]) : 32'd0);
            sched_v[slot][r] = 1'b0;
            vcnt[r] += int'(feature_valid_o[r]);
        end
        if (exp_rd) begin
            for (int r = 0; r < N; r++) begin
                s = (cyc + 2 + r) % 16;
                sched_v[s][r] = 1'b1;
                sched_d[s][r] = mem_words[exp_addr][r*IW +: IW];
            end
        end
        rd_cnt  += int'(mem_rd_en_o);
        end_cnt += int'(end_feature_o);
        if (!f_sel_rst) begin
            case (ph)
                PhIdle: begin
                    if (rd_feature_ld_i) begin
                        next_addr  = base_addrs_i;
                        words_left = int'(feature_len_i);
                        ph         = (words_left > 0) ? PhFetch : PhDone;
                    end
                end
                PhFetch: begin
                    if (!rd_feature_ld_i) begin
                        ph = PhIdle;
                    end else begin
                        next_addr  = next_addr + 1'b1;
                        words_left = words_left - 1;
                        if (words_left == 0) ph = PhDone;
                    end
                end
                default: begin
                    if (!rd_feature_ld_i) ph = PhIdle;
                end
            endcase
            exp_end = (ph == PhDone);
        end
    end

    task automatic clr_cnt();
        for (int r = 0; r < N; r++) vcnt[r] = 0;
        rd_cnt  = 0;
        end_cnt = 0;
    endtask

    task automatic check_cnt(input string tag, input int exp_v, input int exp_rd, input bit exp_e);
        for (int r = 0; r < N; r++) begin
            chk($sformatf("%s valid_cnt[%0d]", tag, r), 32'(vcnt[r]), 32'(exp_v));
        end
        chk({tag, " rd_cnt"}, 32'(rd_cnt), 32'(exp_rd));
        chk({tag, " end_seen"}, 32'(end_cnt != 0), 32'(exp_e));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " mem_rd_en_o"}, 32'(mem_rd_en_o), 32'd0);
        chk({tag, " mem_addrs_o"}, 32'(mem_addrs_o), 32'd0);
        chk({tag, " end_feature_o"}, 32'(end_feature_o), 32'd0);
        for (int r = 0; r < N; r++) begin
            chk($sformatf("%s valid[%0d]", tag, r), 32'(feature_valid_o[r]), 32'd0);
            chk($sformatf("%s data[%0d]", tag, r), 32'(feature_o[r]), 32'd0);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 in an idle cycle.
    task automatic do_pass(input int b, input int l, input int ab, input int hold);
        base_addrs_i    = AW'(b);
        feature_len_i   = AW'(l);
        rd_feature_ld_i = 1'b1;
        if (ab >= 0 && ab < l) begin
            repeat (ab + 1) @(posedge clk_i);
        end else begin
            repeat (l + 1 + hold) @(posedge clk_i);
        end
        #1;
        rd_feature_ld_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        repeat (N + 3) @(posedge clk_i);
        #1;
    endtask

    // Asserts reset between edges and checks the outputs clear before the next edge.
    task automatic do_async_reset(input string tag);
        @(posedge clk_i);
        #2;
        f_sel_rst       = 1'b1;
        rd_feature_ld_i = 1'b0;
        #1;
        chk_all_zero(tag);
        #1;
        f_sel_rst = 1'b0;
        rst_seen  = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int b, l, ab, hold, gap;
        for (int i = 0; i < DEPTH; i++) mem_words[i] = $urandom;
        for (int r = 0; r < N; r++) vcnt[r] = 0;

        repeat (2) @(posedge clk_i);
        #2;
        chk_all_zero("reset");
        #2;
        f_sel_rst = 1'b0;
        rst_seen  = 1'b1;
        @(posedge clk_i);
        #1;

        clr_cnt();
        do_pass(0, 3, -1, 2);
        drain();
        check_cnt("len3", 3, 3, 1'b1);

        clr_cnt();
        do_pass(1022, 4, -1, 0);
        drain();
        check_cnt("wrap", 4, 4, 1'b1);

        clr_cnt();
        do_pass(5, 0, -1, 1);
        drain();
        check_cnt("len0", 0, 0, 1'b1);

        clr_cnt();
        do_pass(100, 5, 2, 0);
        drain();
        check_cnt("abort", 2, 2, 1'b0);

        base_addrs_i    = AW'(200);
        feature_len_i   = AW'(6);
        rd_feature_ld_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        do_async_reset("async_rst");
        clr_cnt();
        drain();
        check_cnt("post_rst", 0, 0, 1'b0);

        clr_cnt();
        do_pass(300, 3, -1, 10);
        do_pass(310, 2, -1, 0);
        drain();
        check_cnt("done_hold", 5, 5, 1'b1);

        clr_cnt();
        do_pass(500, 4, -1, 0);
        do_pass(1020, 6, -1, 0);
        drain();
        check_cnt("b2b", 10, 10, 1'b1);

        for (int k = 0; k < 30; k++) begin
            b    = int'($urandom_range(0, DEPTH - 1));
            l    = int'($urandom_range(0, 8));
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
            hold = int'($urandom_range(0, 3));
            gap  = int'($urandom_range(0, 2));
            do_pass(b, l, ab, hold);
            repeat (gap) @(posedge clk_i);
            #1;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
